// File: rtl/video_timing_pkg.sv
// Shared types, constants and config checks for the video raster timing generator.
package video_timing_pkg;

    localparam int W = 16;

    localparam logic [W-1:0] ZERO_W = {W{1'b0}};
    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [W-1:0] hsw;
        logic [W-1:0] hbp;
        logic [W-1:0] hact;
        logic [W-1:0] hfp;
        logic [W-1:0] vsw;
        logic [W-1:0] vbp;
        logic [W-1:0] vact;
        logic [W-1:0] vfp;
    } timing_cfg_t;

    localparam timing_cfg_t CFG_ZERO = {(8*W){1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } gen_state_t;

    function automatic logic [W+1:0] h_total(input timing_cfg_t c);
        return {2'b00, c.hsw} + {2'b00, c.hbp} + {2'b00, c.hact} + {2'b00, c.hfp};
    endfunction

    function automatic logic [W+1:0] v_total(input timing_cfg_t c);
        return {2'b00, c.vsw} + {2'b00, c.vbp} + {2'b00, c.vact} + {2'b00, c.vfp};
    endfunction

    // Totals are formed two bits wider so an overflow past W bits is visible.
    function automatic logic cfg_valid(input timing_cfg_t c);
        logic [W+1:0] max_total;
        max_total = {2'b00, {W{1'b1}}};
        return (c.hsw != ZERO_W) && (c.hact != ZERO_W) &&
               (c.vsw != ZERO_W) && (c.vact != ZERO_W) &&
               (h_total(c) <= max_total) && (v_total(c) <= max_total);
    endfunction

endpackage

// File: rtl/video_raster_counter.sv
// Pixel/line position counter with line-wrap and frame-wrap strobes.
module video_raster_counter
    import video_timing_pkg::*;
(
    input  logic         i_CLK,
    input  logic         i_RST,
    input  logic         i_run,
    input  logic [W-1:0] i_htotal,
    input  logic [W-1:0] i_vtotal,
    output logic [W-1:0] o_hcnt,
    output logic [W-1:0] o_vcnt,
    output logic         o_line_wrap,
    output logic         o_frame_wrap
);

    logic [W-1:0] hcnt_r;
    logic [W-1:0] vcnt_r;
    logic         line_wrap_s;
    logic         frame_wrap_s;

    // Wrap strobes: last pixel of a line, and last pixel of the last line.
    always_comb begin
        line_wrap_s  = 1'b0;
        frame_wrap_s = 1'b0;
        if (i_run) begin
            line_wrap_s  = (hcnt_r == (i_htotal - ONE_W));
            frame_wrap_s = line_wrap_s && (vcnt_r == (i_vtotal - ONE_W));
        end else begin
            line_wrap_s  = 1'b0;
            frame_wrap_s = 1'b0;
        end
    end

    // Position registers; parked at the origin whenever the raster is not running.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            hcnt_r <= ZERO_W;
            vcnt_r <= ZERO_W;
        end else if (!i_run) begin
            hcnt_r <= ZERO_W;
            vcnt_r <= ZERO_W;
        end else if (line_wrap_s) begin
            hcnt_r <= ZERO_W;
            vcnt_r <= frame_wrap_s ? ZERO_W : (vcnt_r + ONE_W);
        end else begin
            hcnt_r <= hcnt_r + ONE_W;
        end
    end

    assign o_hcnt       = hcnt_r;
    assign o_vcnt       = vcnt_r;
    assign o_line_wrap  = line_wrap_s;
    assign o_frame_wrap = frame_wrap_s;

endmodule

// File: rtl/video_sync_timing_gen.sv
// Programmable raster timing generator: frame-shadowed config, run/stop FSM, registered sync decode.
module video_sync_timing_gen
    import video_timing_pkg::*;
(
    input  logic         i_CLK,
    input  logic         i_RST,
    input  logic         i_en,
    input  logic [W-1:0] i_hsw,
    input  logic [W-1:0] i_hbp,
    input  logic [W-1:0] i_hact,
    input  logic [W-1:0] i_hfp,
    input  logic [W-1:0] i_vsw,
    input  logic [W-1:0] i_vbp,
    input  logic [W-1:0] i_vact,
    input  logic [W-1:0] i_vfp,
    output logic         o_hsync,
    output logic         o_vsync,
    output logic         o_de,
    output logic         o_sof,
    output logic [W-1:0] o_hcnt,
    output logic [W-1:0] o_vcnt,
    output logic         o_cfg_err
);

    gen_state_t   state_r;
    gen_state_t   next_state_s;
    timing_cfg_t  shadow_r;
    timing_cfg_t  in_cfg_s;
    logic         in_ok_s;
    logic         load_s;
    logic         err_set_s;
    logic         cfg_err_r;
    logic         run_s;
    logic         line_wrap_s;
    logic         frame_wrap_s;
    logic         frame_end_s;
    logic [W-1:0] htotal_s;
    logic [W-1:0] vtotal_s;
    logic [W-1:0] hcnt_s;
    logic [W-1:0] vcnt_s;
    logic [W+1:0] hstart_s;
    logic [W+1:0] hend_s;
    logic [W+1:0] vstart_s;
    logic [W+1:0] vend_s;
    logic         hsync_s;
    logic         vsync_s;
    logic         de_s;
    logic         sof_s;
    logic         hsync_r;
    logic         vsync_r;
    logic         de_r;
    logic         sof_r;
    logic [W-1:0] out_hcnt_r;
    logic [W-1:0] out_vcnt_r;

    assign in_cfg_s = {i_hsw, i_hbp, i_hact, i_hfp, i_vsw, i_vbp, i_vact, i_vfp};
    assign in_ok_s  = cfg_valid(in_cfg_s);
    assign run_s    = (state_r != IDLE);
    // The shadow only ever holds a validated config, so its totals fit in W bits.
    assign htotal_s = W'(h_total(shadow_r));
    assign vtotal_s = W'(v_total(shadow_r));
    // A frame wrap is by construction also a line wrap.
    assign frame_end_s = line_wrap_s & frame_wrap_s;

    video_raster_counter u_counter (
        .i_CLK        (i_CLK),
        .i_RST        (i_RST),
        .i_run        (run_s),
        .i_htotal     (htotal_s),
        .i_vtotal     (vtotal_s),
        .o_hcnt       (hcnt_s),
        .o_vcnt       (vcnt_s),
        .o_line_wrap  (line_wrap_s),
        .o_frame_wrap (frame_wrap_s)
    );

    // Next-state, shadow load and error-set decisions.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_en) begin
                    if (in_ok_s) begin
                        next_state_s = RUN;
                        load_s       = 1'b1;
                    end else begin
                        err_set_s    = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN, STOP: begin
                if (i_en) begin
                    next_state_s = RUN;
                    if (frame_end_s) begin
                        load_s    = in_ok_s;
                        err_set_s = !in_ok_s;
                    end else begin
                        load_s    = 1'b0;
                    end
                end else if (frame_end_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = STOP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, shadow config and sticky config error.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_r   <= IDLE;
            shadow_r  <= CFG_ZERO;
            cfg_err_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (load_s) begin
                shadow_r <= in_cfg_s;
            end
            if (err_set_s) begin
                cfg_err_r <= 1'b1;
            end
        end
    end

    // Raster decode of the current counter position against the shadow config.
    always_comb begin
        hstart_s = {2'b00, shadow_r.hsw} + {2'b00, shadow_r.hbp};
        hend_s   = hstart_s + {2'b00, shadow_r.hact};
        vstart_s = {2'b00, shadow_r.vsw} + {2'b00, shadow_r.vbp};
        vend_s   = vstart_s + {2'b00, shadow_r.vact};
        hsync_s  = (hcnt_s < shadow_r.hsw);
        vsync_s  = (vcnt_s < shadow_r.vsw);
        de_s     = ({2'b00, hcnt_s} >= hstart_s) && ({2'b00, hcnt_s} < hend_s) &&
                   ({2'b00, vcnt_s} >= vstart_s) && ({2'b00, vcnt_s} < vend_s);
        sof_s    = (hcnt_s == ZERO_W) && (vcnt_s == ZERO_W);
    end

    // Output stage: one cycle behind the counters, forced low outside RUN/STOP.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            hsync_r    <= 1'b0;
            vsync_r    <= 1'b0;
            de_r       <= 1'b0;
            sof_r      <= 1'b0;
            out_hcnt_r <= ZERO_W;
            out_vcnt_r <= ZERO_W;
        end else if (run_s) begin
            hsync_r    <= hsync_s;
            vsync_r    <= vsync_s;
            de_r       <= de_s;
            sof_r      <= sof_s;
            out_hcnt_r <= hcnt_s;
            out_vcnt_r <= vcnt_s;
        end else begin
            hsync_r    <= 1'b0;
            vsync_r    <= 1'b0;
            de_r       <= 1'b0;
            sof_r      <= 1'b0;
            out_hcnt_r <= ZERO_W;
            out_vcnt_r <= ZERO_W;
        end
    end

    assign o_hsync   = hsync_r;
    assign o_vsync   = vsync_r;
    assign o_de      = de_r;
    assign o_sof     = sof_r;
    assign o_hcnt    = out_hcnt_r;
    assign o_vcnt    = out_vcnt_r;
    assign o_cfg_err = cfg_err_r;

endmodule
